led_breathe_pwm: RTL and testbench

LED_BREATHE_PWM -- requirements
Module: led_breathe_pwm

---
 rtl/led_breathe_pwm.sv | 178 +++++++++++++++++
 tb/tb_led_breathe_pwm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe_pwm.sv
// Two-colour "breathing" LED driver: a triangular brightness ramp with
// plateaus, rendered as glitch-free PWM on a green / red LED pair.
//
// Ports:
//   CLK     sole clock (12 MHz board oscillator)
//   RST     asynchronous, active-high reset
//   EN      synchronous run enable; 0 forces IDLE with both LEDs off
//   TICK    single-CLK ramp strobe from an upstream prescaler
//   LEDG_N  green LED, active low, duty = LEVEL
//   LEDR_N  red LED, active low, duty = MAX - LEVEL
//   LEVEL   current brightness level register
//   PHASE   state code: IDLE=0 RISE=1 HOLD_HI=2 FALL=3 HOLD_LO=4

module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 64
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                TICK,
    output logic                LEDG_N,
    output logic                LEDR_N,
    output logic [PWM_BITS-1:0] LEVEL,
    output logic [2:0]          PHASE
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RISE    = 3'd1;
    localparam logic [2:0] S_HOLD_HI = 3'd2;
    localparam logic [2:0] S_FALL    = 3'd3;
    localparam logic [2:0] S_HOLD_LO = 3'd4;

    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [2:0]          state;
    logic [2:0]          state_nx;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_nx;
    logic [HW-1:0]       hold_cnt;
    logic [HW-1:0]       hold_nx;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_g;
    logic [PWM_BITS-1:0] duty_r;
    logic                green_on;
    logic                red_on;
    logic                led_g_n;
    logic                led_r_n;

    logic [PWM_BITS:0]   sum_up;
    logic [PWM_BITS-1:0] up_val;
    logic [PWM_BITS-1:0] dn_val;
    logic                plateau_done;

    // Saturating ramp arithmetic: one extra bit catches overflow on the
    // way up, and a compare against STEP prevents underflow on the way down.
    always_comb begin
        sum_up = {1'b0, level} + STEP_X;
        up_val = sum_up[PWM_BITS] ? MAX : sum_up[PWM_BITS-1:0];
        if ({1'b0, level} <= STEP_X) begin
            dn_val = '0;
        end else begin
            dn_val = level - STEP_X[PWM_BITS-1:0];
        end
    end

    // A plateau lasts HOLD_TICKS ticks: the tick that finds the counter
    // already at its last value is the one that leaves.
    assign plateau_done = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nx = state;
        level_nx = level;
        hold_nx  = hold_cnt;
        if (!EN) begin
            // Disable wins over any tick arriving in the same cycle.
            state_nx = S_IDLE;
            level_nx = '0;
            hold_nx  = '0;
        end else if (state == S_IDLE) begin
            // Start-up cycle: a coincident tick is deliberately ignored.
            state_nx = S_RISE;
        end else if (state > S_HOLD_LO) begin
            state_nx = S_IDLE;
            level_nx = '0;
            hold_nx  = '0;
        end else if (TICK) begin
            case (state)
                S_RISE: begin
                    level_nx = up_val;
                    if (up_val == MAX) begin
                        state_nx = S_HOLD_HI;
                        hold_nx  = '0;
                    end
                end
                S_HOLD_HI: begin
                    if (plateau_done) begin
                        state_nx = S_FALL;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                S_FALL: begin
                    level_nx = dn_val;
                    if (dn_val == '0) begin
                        state_nx = S_HOLD_LO;
                        hold_nx  = '0;
                    end
                end
                S_HOLD_LO: begin
                    if (plateau_done) begin
                        state_nx = S_RISE;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            level    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            level    <= level_nx;
            hold_cnt <= hold_nx;
        end
    end

    assign green_on = (pwm_cnt < duty_g);
    assign red_on   = (pwm_cnt < duty_r);

    // Duties are only reloaded as the counter wraps, so a level change
    // never truncates or stretches the pulse already in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pwm_cnt <= '0;
            duty_g  <= '0;
            duty_r  <= '0;
            led_g_n <= 1'b1;
            led_r_n <= 1'b1;
        end else if (!EN) begin
            pwm_cnt <= '0;
            duty_g  <= '0;
            duty_r  <= '0;
            led_g_n <= 1'b1;
            led_r_n <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == MAX) begin
                duty_g <= level;
                duty_r <= MAX - level;
            end
            led_g_n <= ~green_on;
            led_r_n <= ~red_on;
        end
    end

    assign LEDG_N = led_g_n;
    assign LEDR_N = led_r_n;
    assign LEVEL  = level;
    assign PHASE  = state;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Randomised and directed bench for led_breathe_pwm: two instances
// (STEP=1/HOLD=64 and STEP=100/HOLD=3) against an integer reference model.

module tb_led_breathe_pwm;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       en   = 1'b0;
    logic       tick = 1'b0;
    logic       g0, r0, g1, r1;
    logic [7:0] lv0, lv1;
    logic [2:0] ph0, ph1;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

    led_breathe_pwm #(.PWM_BITS(8), .STEP(1), .HOLD_TICKS(64)) u_dut0 (
        .CLK(clk), .RST(rst), .EN(en), .TICK(tick),
        .LEDG_N(g0), .LEDR_N(r0), .LEVEL(lv0), .PHASE(ph0)
    );

    led_breathe_pwm #(.PWM_BITS(8), .STEP(100), .HOLD_TICKS(3)) u_dut1 (
        .CLK(clk), .RST(rst), .EN(en), .TICK(tick),
        .LEDG_N(g1), .LEDR_N(r1), .LEVEL(lv1), .PHASE(ph1)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: plain integers, brightness in 0..255.
    int steps[2] = '{1, 100};
    int holds[2] = '{64, 3};
    int m_lvl[2], m_ph[2], m_hold[2];
    int m_pwm[2], m_dg[2], m_dr[2], m_g[2], m_r[2];

    always @(posedge clk or posedge rst) begin
        int nl;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_lvl[i] <= 0; m_ph[i] <= 0; m_hold[i] <= 0;
                m_pwm[i] <= 0; m_dg[i] <= 0; m_dr[i] <= 0;
                m_g[i] <= 1; m_r[i] <= 1;
            end else begin
                if (!en) begin
                    m_pwm[i] <= 0; m_dg[i] <= 0; m_dr[i] <= 0;
                    m_g[i] <= 1; m_r[i] <= 1;
                end else begin
                    m_g[i] <= (m_pwm[i] < m_dg[i]) ? 0 : 1;
                    m_r[i] <= (m_pwm[i] < m_dr[i]) ? 0 : 1;
                    if (m_pwm[i] == 255) begin
                        m_dg[i] <= m_lvl[i];
                        m_dr[i] <= 255 - m_lvl[i];
                    end
                    m_pwm[i] <= (m_pwm[i] + 1) % 256;
                end
                if (!en) begin
                    m_ph[i] <= 0; m_lvl[i] <= 0; m_hold[i] <= 0;
                end else if (m_ph[i] == 0) begin
                    m_ph[i] <= 1;
                end else if (tick) begin
                    if (m_ph[i] == 1) begin
                        nl = m_lvl[i] + steps[i];
                        if (nl > 255) nl = 255;
                        m_lvl[i] <= nl;
                        if (nl == 255) begin m_ph[i] <= 2; m_hold[i] <= 0; end
                    end else if (m_ph[i] == 3) begin
                        nl = m_lvl[i] - steps[i];
                        if (nl < 0) nl = 0;
                        m_lvl[i] <= nl;
                        if (nl == 0) begin m_ph[i] <= 4; m_hold[i] <= 0; end
                    end else if (m_hold[i] == holds[i] - 1) begin
                        m_ph[i] <= (m_ph[i] == 2) ? 3 : 1;
                        m_hold[i] <= 0;
                    end else begin
                        m_hold[i] <= m_hold[i] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("g0", g0, m_g[0]);   chk("r0", r0, m_r[0]);
            chk("lv0", lv0, m_lvl[0]); chk("ph0", ph0, m_ph[0]);
            chk("g1", g1, m_g[1]);   chk("r1", r1, m_r[1]);
            chk("lv1", lv1, m_lvl[1]); chk("ph1", ph1, m_ph[1]);
        end
    end

    task automatic check_tick(input int n);
        if (n == 255) begin chk("top_lvl", lv0, 255); chk("top_ph", ph0, 2); end
        if (n == 318) chk("hold_hi_last", ph0, 2);
        if (n == 319) begin chk("fall_ph", ph0, 3); chk("fall_lvl", lv0, 255); end
        if (n == 320) chk("fall_first", lv0, 254);
        if (n == 574) begin chk("lo_ph", ph0, 4); chk("lo_lvl", lv0, 0); end
        if (n == 637) chk("hold_lo_last", ph0, 4);
        if (n == 638) chk("rerise_ph", ph0, 1);
        if (n == 639) chk("rerise_lvl", lv0, 1);
        case (n)
            1:  begin chk("s100_1", lv1, 100); chk("s100_1ph", ph1, 1); end
            2:  chk("s100_2", lv1, 200);
            3:  begin chk("s100_sat", lv1, 255); chk("s100_hh", ph1, 2); end
            5:  chk("s100_hold", ph1, 2);
            6:  begin chk("s100_fall", ph1, 3); chk("s100_fl", lv1, 255); end
            7:  chk("s100_155", lv1, 155);
            8:  chk("s100_55", lv1, 55);
            9:  begin chk("s100_0", lv1, 0); chk("s100_hl", ph1, 4); end
            12: chk("s100_rise", ph1, 1);
            default: ;
        endcase
    endtask

    initial begin
        int gl, rl;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        chk("rst_lvl", lv0, 0); chk("rst_ph", ph0, 0);
        chk("rst_g", g0, 1);    chk("rst_r", r0, 1);
        rst = 1'b0;

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            tick = 1'($urandom_range(0, 1));
        end
        chk("idle_ph", ph0, 0); chk("idle_g", g0, 1); chk("idle_r", r0, 1);

        @(negedge clk); en = 1'b1; tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        chk("start_ph", ph0, 1); chk("start_lvl", lv0, 0); chk("start_lvl1", lv1, 0);

        for (int n = 1; n <= 640; n++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check_tick(n);
            repeat (3) @(negedge clk);
        end

        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            tick = ($urandom_range(0, 2) == 0);
            en   = ($urandom_range(0, 499) != 0);
        end

        @(negedge clk); en = 1'b0; tick = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int c = 0; c < 200 && m_lvl[0] != 64; c++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
        chk("reach64", lv0, 64);
        repeat (300) @(negedge clk);
        gl = 0; rl = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (g0 == 1'b0) gl++;
            if (r0 == 1'b0) rl++;
        end
        chk("duty_g64", gl, 64);
        chk("duty_r191", rl, 191);

        for (int c = 0; c < 1000 && !(m_ph[0] == 3 && m_lvl[0] == 120); c++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        chk("at120_lvl", lv0, 120); chk("at120_ph", ph0, 3);
        en = 1'b0; tick = 1'b1;
        @(negedge clk);
        chk("drop_ph", ph0, 0); chk("drop_lvl", lv0, 0);
        chk("drop_g", g0, 1);   chk("drop_r", r0, 1);
        en = 1'b1; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("reen_ph", ph0, 1); chk("reen_lvl", lv0, 0);

        for (int c = 0; c < 400 && m_ph[0] != 2; c++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
        chk("hh_ph", ph0, 2);
        repeat (5) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_ph", ph0, 0); chk("arst_lvl", lv0, 0);
        chk("arst_g", g0, 1);   chk("arst_r", r0, 1);
        chk("arst_lvl1", lv1, 0);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            tick = 1'($urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
